// File: rtl/turn_controller.sv
// Turn sequencer for an N-player, N-cell board game: cursor movement over free
// cells, commit strobe to the board, random free-cell pick on turn timeout.
module turn_controller #(
  parameter int N_PLAYERS      = 2,
  parameter int N_CELLS        = 9,
  parameter int TIMEOUT_CYCLES = 1500000000,
  parameter int POS_W          = $clog2(N_CELLS),
  parameter int PLY_W          = $clog2(N_PLAYERS + 1)
) (
  input  logic               clk,
  input  logic               hrd_rst,
  input  logic               start,
  input  logic               move_b,
  input  logic               select,
  input  logic [N_CELLS-1:0] busy_map,
  input  logic               win,
  input  logic               full,
  output logic               rst,
  output logic               w_e,
  output logic [POS_W-1:0]   pos,
  output logic [PLY_W-1:0]   player,
  output logic [PLY_W-1:0]   winner,
  output logic               winner_s,
  output logic               timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_TURN, S_PROBE, S_WRITE, S_CHECK, S_DONE
  } state_t;

  state_t           state;
  logic [POS_W-1:0] cursor;
  logic [POS_W-1:0] probe;
  logic [31:0]      timer;
  logic [15:0]      lfsr;

  logic [POS_W-1:0] next_free;
  logic             found;
  logic [POS_W:0]   sum;
  logic [POS_W-1:0] idx;
  logic [POS_W-1:0] rnd;
  logic             sel_ok;
  logic             timer_end;

  // Nearest free cell after the cursor, wrapping; holds if none other is free.
  always_comb begin
    next_free = cursor;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 1; k < N_CELLS; k++) begin
      sum = {1'b0, cursor} + (POS_W+1)'(k);
      if (sum >= (POS_W+1)'(N_CELLS))
        sum = sum - (POS_W+1)'(N_CELLS);
      idx = sum[POS_W-1:0];
      if (!found && !busy_map[idx]) begin
        next_free = idx;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    rnd = lfsr[POS_W-1:0];
    if ({1'b0, lfsr[POS_W-1:0]} >= (POS_W+1)'(N_CELLS))
      rnd = POS_W'({1'b0, lfsr[POS_W-1:0]} - (POS_W+1)'(N_CELLS));
  end

  assign sel_ok    = select && !busy_map[cursor];
  assign timer_end = (timer == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (hrd_rst) begin
      state     <= S_IDLE;
      cursor    <= '0;
      probe     <= '0;
      pos       <= '0;
      player    <= PLY_W'(1);
      winner    <= '0;
      timer     <= '0;
      lfsr      <= 16'hACE1;
      rst       <= 1'b0;
      w_e       <= 1'b0;
      winner_s  <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      rst       <= 1'b0;
      w_e       <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CLEAR;
            rst   <= 1'b1;
          end
        end
        S_CLEAR: begin
          player <= PLY_W'(1);
          cursor <= '0;
          pos    <= '0;
          winner <= '0;
          timer  <= '0;
          state  <= S_TURN;
        end
        S_TURN: begin
          if (sel_ok) begin
            pos   <= cursor;
            w_e   <= 1'b1;
            state <= S_WRITE;
          end else if (timer_end) begin
            probe <= rnd;
            pos   <= rnd;
            state <= S_PROBE;
          end else begin
            timer <= timer + 32'd1;
            // Registered pulse lands in the cycle where the timer hits its end.
            if (timer == 32'(TIMEOUT_CYCLES - 2))
              timeout_o <= 1'b1;
            if (move_b) begin
              cursor <= next_free;
              pos    <= next_free;
            end
          end
        end
        S_PROBE: begin
          if (!busy_map[probe]) begin
            w_e   <= 1'b1;
            state <= S_WRITE;
          end else begin
            probe <= (probe == POS_W'(N_CELLS - 1)) ? '0 : probe + 1'b1;
            pos   <= (probe == POS_W'(N_CELLS - 1)) ? '0 : probe + 1'b1;
          end
        end
        S_WRITE: state <= S_CHECK;
        S_CHECK: begin
          if (win) begin
            winner   <= player;
            winner_s <= 1'b1;
            state    <= S_DONE;
          end else if (full) begin
            winner   <= '0;
            winner_s <= 1'b1;
            state    <= S_DONE;
          end else begin
            player <= (player == PLY_W'(N_PLAYERS)) ? PLY_W'(1) : player + 1'b1;
            timer  <= '0;
            pos    <= cursor;
            state  <= S_TURN;
          end
        end
        S_DONE: begin
          if (start) begin
            winner_s <= 1'b0;
            rst      <= 1'b1;
            state    <= S_CLEAR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/turn_controller.md
# turn_controller

Parametrised turn sequencer for the board-game datapath, the successor to the two-player nine-cell game controller. It supports N players on an N-cell board and keeps a cursor that skips occupied cells. On timeout it picks a random free cell by LFSR draw plus linear probing. It sits between the debounced button inputs and the board memory/evaluator: it drives the write strobe, cell index and player code, and consumes the board's occupancy map and the win/full flags.

## Interface
- N_PLAYERS, 2: number of players, legal range 2..4; player codes are 1..N_PLAYERS, and 0 means none/draw.
- N_CELLS, 9: number of board cells, legal range 2..16.
- TIMEOUT_CYCLES, 1500000000: length of a turn in clk cycles (30 s at 50 MHz); legal range ≥2, counter is 32 bits.
- POS_W, $clog2(N_CELLS): derived, not overridden.
- PLY_W, $clog2(N_PLAYERS+1): derived, not overridden.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- hrd_rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new game; honoured only in IDLE or DONE.
- move_b  in  1  one-cycle pulse that advances the cursor to the next free cell; honoured only in TURN.
- select  in  1  one-cycle pulse that commits the cell under the cursor; honoured only in TURN.
- busy_map  in  N_CELLS  bit i=1 means cell i is occupied.
- win  in  1  board evaluator flag; sampled only in CHECK.
- full  in  1  board evaluator flag; sampled only in CHECK.
- rst  out  1  board clear strobe.
- w_e  out  1  board write strobe.
- pos  out  POS_W  cell index.
- player  out  PLY_W  current player code.
- winner  out  PLY_W  result of the finished game (0 = draw).
- winner_s  out  1  high while the result is displayed.
- timeout_o  out  1  one-cycle pulse when a turn times out.

## Operation
- States: IDLE, CLEAR, TURN, PROBE, WRITE, CHECK, DONE.
- Reset state: IDLE. Register reset values:
  - cursor, probe, pos = 0; player = 1; winner = 0; timer = 0; LFSR = 16'hACE1.
  - rst, w_e, winner_s, timeout_o = 0.
- IDLE: start → CLEAR.
- CLEAR: rst=1 for exactly one cycle; player←1, cursor←0, winner←0 → TURN.
- TURN:
  - pos = cursor. Timer increments every cycle.
  - select with busy_map[cursor]=0 → WRITE, committed index ← cursor.
  - select with busy_map[cursor]=1: ignored, no state change.
  - move_b: cursor ← first i with busy_map[i]=0, searching cursor+1, cursor+2, … and wrapping N_CELLS-1→0. If no other cell is free, cursor holds.
  - Timer reaching TIMEOUT_CYCLES-1: timeout_o=1 that cycle; probe ← reduced LFSR value → PROBE.
  - Priority in one cycle: select (valid) > timeout > move_b.
- Random reduction: take r = LFSR[POS_W-1:0]. If r ≥ N_CELLS, the result is r−N_CELLS; otherwise it is r. A single subtraction is sufficient.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle in every state except reset.
- PROBE: pos = probe.
  - busy_map[probe]=0 → WRITE, committed index ← probe.
  - Otherwise probe ← probe+1, wrapping N_CELLS-1→0.
  - A free cell always exists, because TURN is entered only when full=0. PROBE therefore lasts at most N_CELLS cycles.
- WRITE: w_e=1 for exactly one cycle, with pos = committed index and player = current player → CHECK.
- CHECK: board outputs reflect the write.
  - win=1 → DONE, winner←player.
  - Else full=1 → DONE, winner←0.
  - Else player ← (player==N_PLAYERS) ? 1 : player+1, timer←0 → TURN.
- DONE: winner_s=1; start → CLEAR. move_b and select are ignored.
- The cursor is not moved between turns. The next player starts from the previous cursor, even if that cell is now busy; select on it is ignored until move_b is pressed.
- Timer is cleared on every entry to TURN and holds in all other states.
- hrd_rst in any state returns all registers to reset values at that edge. An in-flight w_e is dropped the following cycle, and no partial write is repeated.

## Timing
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Select accepted at edge k: WRITE (w_e=1) during cycle k+1, CHECK k+2, next TURN k+3.
- Timeout: timeout_o is asserted in the TIMEOUT_CYCLES-th cycle of TURN, counting the entry cycle as 1. w_e follows 2 to N_CELLS+1 cycles later.
- start in DONE → rst in the next cycle → TURN one cycle after that.
- rst and w_e are never high in the same cycle.

## Test plan
Bench parameters for all scenarios: N_PLAYERS=3, N_CELLS=9, TIMEOUT_CYCLES=16.

1. Reset then start → rst high for 1 cycle; player=1, pos=0, timer=0 in TURN.
2. busy_map=9'b000000110, cursor=0, move_b → cursor=3. Select → one w_e pulse with pos=3, player=1. After CHECK (win=0, full=0) → player=2. Repeat twice more → player sequence 1,2,3,1.
3. No input for 16 cycles in TURN → timeout_o pulse in cycle 16. With busy_map=9'b111111110 → probe wraps; w_e fires with pos=0 within 10 cycles of timeout_o.
4. select on a busy cursor cell → no w_e; timer keeps counting. select and move_b in the same cycle on a free cell → write at the old cursor.
5. win=1 in CHECK while player=2 → DONE, winner=2, winner_s=1. Separately, full=1 with win=0 → winner=0. start in DONE → rst pulse, player=1.
6. hrd_rst asserted in the WRITE cycle → IDLE at next edge; w_e=0, player=1, pos=0, winner_s=0; subsequent select and move_b are ignored.
